seller_coin_feeder: RTL
=======================

// Module: seller_coin_feeder
// PURPOSE
// Customer-side initiator for the seller vending FSM: on a purchase request it drives the
// seller's coin inputs (d1 = 0.5 yuan, d2 = 1 yuan) and drink select (sel) as a paced stream of
// one-cycle coin pulses, then watches the seller's out1/out2/out3 to confirm vend and change.
// Used as the bench/system stimulus source for seller2-class blocks.
// PARAMETERS
// GAP       default 1  idle cycles between consecutive coin pulses (0 = back-to-back)
// TIMEOUT   default 4  cycles allowed after the last coin pulse for a vend response
// CNT_W     default 4  width of gap/timeout/paid counters; must hold max(GAP,TIMEOUT,6)
// PORTS
// clk        in   1      clock
// rst        in   1      asynchronous reset, active-high
// start      in   1      request purchase; sampled in IDLE only
// drink      in   1      0 = drink A (price 3 units = 1.5 yuan), 1 = drink B (5 units = 2.5 yuan)
// mode       in   2      0 greedy, 1 half-coins only, 2 overpay by 1 unit, 3 = treated as 0
// d1         out  1      0.5-yuan coin pulse to seller
// d2         out  1      1-yuan coin pulse to seller
// sel        out  1      drink select to seller, held for the whole transaction
// out1       in   1      seller drink-A vend
// out2       in   1      seller drink-B vend
// out3       in   1      seller change (0.5 yuan)
// busy       out  1      high from cycle after accepted start until done
// done       out  1      one-cycle pulse ending a transaction
// vend_ok    out  1      valid with done: correct drink vended and change matched expectation
// err        out  1      valid with done: timeout, wrong drink, early vend, or change mismatch
// paid       out  CNT_W  units (0.5 yuan) inserted in current/last transaction
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; d1,d2,sel,busy,done,vend_ok,err = 0; paid = 0.
// - All outputs registered. d1 and d2 never high in the same cycle.
// - States: IDLE -> COIN -> GAP -> COIN ... -> WAIT -> DONE -> IDLE.
// - IDLE: on start=1 latch drink, mode; sel <= drink; target = price (3 or 5), +1 if mode=2;
//   paid <= 0; busy <= 1; next COIN. start while busy is ignored (no queueing).
// - COIN (one cycle): remaining = target - paid. mode 1: d1. Else d2 if remaining >= 2, else d1.
//   paid += 2 (d2) or 1 (d1). If paid reaches target -> WAIT, else GAP (or COIN if GAP=0).
// - Coin sequences: A greedy d2,d1; A half d1x3; A overpay d2,d2; B greedy d2,d2,d1;
//   B half d1x5; B overpay d2,d2,d2.
// - GAP: count GAP cycles with d1=d2=0, then COIN.
// - WAIT: entered the cycle after the last coin pulse; seller response appears there
//   (seller registers outputs on the coin edge). Capture first cycle with out1|out2;
//   expect out1 for drink A / out2 for drink B; expect out3 = (mode==2). Any mismatch -> err.
//   No response within TIMEOUT cycles -> err. Either outcome -> DONE.
// - out1|out2 seen in COIN/GAP (before target reached) -> err, abort to DONE immediately.
// - DONE: done=1, busy=0, vend_ok = !err, for exactly one cycle; sel held until IDLE; paid
//   holds until next accepted start.
// - drink/mode changes while busy are ignored; sel never toggles mid-transaction.
// - Reset mid-transaction: all outputs drop asynchronously, no done pulse, paid cleared.
// - paid saturates conceptually at 6; counters never wrap within legal parameters.
// STRUCTURE
// - Shared package seller_pkg: unit constants PRICE_A=3, PRICE_B=5, mode encodings
//   (MODE_GREEDY, MODE_HALF, MODE_OVER), feeder state enum; shared with seller FSM benches.
// - Single module; one natural sub-module seller_feeder_timer (loadable down-counter used for
//   both GAP and TIMEOUT, with zero flag). No other hierarchy.
// TESTING
// - drink=0,mode=0,GAP=1: d2@c1, idle c2, d1@c3; seller out1=1 @c4 -> done, vend_ok=1, paid=3.
// - drink=1,mode=2: d2,d2,d2; seller out2=1,out3=1 -> vend_ok=1, paid=6; out3=0 -> err=1.
// - drink=1,mode=1: five d1 pulses each separated by GAP idles; out2 -> vend_ok=1, paid=5.
// - No seller response: WAIT lasts exactly TIMEOUT=4 cycles, then done with err=1, vend_ok=0.
// - out1 injected after first coin of drink B -> abort, done with err=1, no further coins.
// - rst pulse during GAP of drink B: d1,d2,busy,sel drop at once, no done; new start
//   afterwards runs full sequence from paid=0; start during busy produces no second run.

Source files
------------

// File: rtl/seller_pkg.sv
// Shared constants and helpers for the seller vending FSM and its coin feeder.
// Prices and paid amounts are in units of 0.5 yuan.
package seller_pkg;

  localparam int unsigned PRICE_A  = 32'd3;
  localparam int unsigned PRICE_B  = 32'd5;
  localparam int unsigned PAID_MAX = 32'd6;

  localparam logic [1:0] MODE_GREEDY = 2'd0;
  localparam logic [1:0] MODE_HALF   = 2'd1;
  localparam logic [1:0] MODE_OVER   = 2'd2;

  typedef logic [2:0] feeder_state_t;
  localparam feeder_state_t ST_IDLE = 3'd0;
  localparam feeder_state_t ST_COIN = 3'd1;
  localparam feeder_state_t ST_GAP  = 3'd2;
  localparam feeder_state_t ST_WAIT = 3'd3;
  localparam feeder_state_t ST_DONE = 3'd4;

  function automatic int unsigned drink_target(input logic drink, input logic [1:0] mode);
    int unsigned price;
    price = drink ? PRICE_B : PRICE_A;
    return (mode == MODE_OVER) ? price + 32'd1 : price;
  endfunction

  function automatic int unsigned paid_sat(input int unsigned paid, input int unsigned add);
    int unsigned sum;
    sum = paid + add;
    return (sum > PAID_MAX) ? PAID_MAX : sum;
  endfunction

endpackage

// File: rtl/seller_feeder_timer.sv
// Loadable down-counter shared by the coin-gap and vend-timeout phases.
// Load has priority over decrement; the count holds at zero.
module seller_feeder_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: load, decrement or hold
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/seller_coin_feeder.sv
// Customer-side coin feeder: pays for one drink with paced d1/d2 pulses, then
// checks the seller's vend and change response.
module seller_coin_feeder
  import seller_pkg::*;
#(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             drink,
  input  logic [1:0]       mode,
  output logic             d1,
  output logic             d2,
  output logic             sel,
  input  logic             out1,
  input  logic             out2,
  input  logic             out3,
  output logic             busy,
  output logic             done,
  output logic             vend_ok,
  output logic             err,
  output logic [CNT_W-1:0] paid
);

  // Timer reload values: a phase of N cycles loads N-1 and ends on the zero flag.
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  feeder_state_t    state_q, state_d;
  logic             d1_q, d1_d, d2_q, d2_d, sel_q, sel_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             vend_ok_q, vend_ok_d, err_q, err_d;
  logic [CNT_W-1:0] paid_q, paid_d, target_q, target_d;
  logic             drink_q, drink_d, half_q, half_d, over_q, over_d;

  logic [CNT_W-1:0] base_paid_s, base_target_s, tmr_val_s;
  logic             base_half_s, two_s, issue_s;
  logic             tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic             vend_seen_s, vend_good_s;

  seller_feeder_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .zero_o     (tmr_zero_s)
  );

  // coin choice: the first coin is chosen from the live inputs, later ones from latched state
  always_comb begin
    if (state_q == ST_IDLE) begin
      base_paid_s   = {CNT_W{1'b0}};
      base_target_s = CNT_W'(drink_target(drink, mode));
      base_half_s   = (mode == MODE_HALF);
    end else begin
      base_paid_s   = paid_q;
      base_target_s = target_q;
      base_half_s   = half_q;
    end
    two_s       = !base_half_s && ((base_target_s - base_paid_s) >= CNT_W'(2));
    vend_seen_s = out1 | out2;
    vend_good_s = (drink_q ? (out2 & ~out1) : (out1 & ~out2)) && (out3 == over_q);
  end

  // transaction FSM and registered output next-state
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vend_ok_d  = 1'b0;
    err_d      = 1'b0;
    paid_d     = paid_q;
    target_d   = target_q;
    drink_d    = drink_q;
    half_d     = half_q;
    over_d     = over_q;
    issue_s    = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};
    tmr_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          drink_d  = drink;
          half_d   = (mode == MODE_HALF);
          over_d   = (mode == MODE_OVER);
          target_d = base_target_s;
          sel_d    = drink;
          busy_d   = 1'b1;
          issue_s  = 1'b1;
          state_d  = ST_COIN;
        end else begin
          sel_d = 1'b0;
        end
      end
      ST_COIN: begin
        if (vend_seen_s) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (paid_q >= target_q) begin
          state_d    = ST_WAIT;
          tmr_load_s = 1'b1;
          tmr_val_s  = TO_LD;
        end else if (GAP == 0) begin
          issue_s = 1'b1;
        end else begin
          state_d    = ST_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (vend_seen_s) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (tmr_zero_s) begin
          issue_s = 1'b1;
          state_d = ST_COIN;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (vend_seen_s) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          vend_ok_d = vend_good_s;
          err_d     = !vend_good_s;
        end else if (tmr_zero_s) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sel_d   = 1'b0;
      end
    endcase
    if (issue_s) begin
      d2_d   = two_s;
      d1_d   = !two_s;
      paid_d = CNT_W'(paid_sat(32'(base_paid_s), two_s ? 32'd2 : 32'd1));
    end else begin
      d2_d = 1'b0;
      d1_d = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      d1_q      <= 1'b0;
      d2_q      <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vend_ok_q <= 1'b0;
      err_q     <= 1'b0;
      paid_q    <= {CNT_W{1'b0}};
      target_q  <= {CNT_W{1'b0}};
      drink_q   <= 1'b0;
      half_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vend_ok_q <= vend_ok_d;
      err_q     <= err_d;
      paid_q    <= paid_d;
      target_q  <= target_d;
      drink_q   <= drink_d;
      half_q    <= half_d;
      over_q    <= over_d;
    end
  end

  assign d1      = d1_q;
  assign d2      = d2_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vend_ok = vend_ok_q;
  assign err     = err_q;
  assign paid    = paid_q;

endmodule
